uart_tx_cts: RTL and testbench

// - 8N1 UART transmitter with a small input FIFO and CTS flow control. It is the far end of the RTS

---
 rtl/uart_tx_cts.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_cts.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cts.sv
// uart_tx_cts: 8N1 UART transmitter fed by a small byte FIFO, with frame starts
// gated by a synchronized clear-to-send input from the peer.
module uart_tx_cts #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [7:0]                        data_i,
    input  logic                              cts_i,
    output logic                              tx_serial_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CW           = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // CTS synchronizer
    logic cts_meta_r;
    logic cts_sync_r;

    // FIFO
    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             ready_r;
    logic             push_s;
    logic             pop_s;
    logic [7:0]       head_s;
    logic             start_ok_s;

    // Serializer
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_next_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_next_s;
    logic             tx_r;
    logic             tx_next_s;
    logic             busy_r;

    assign push_s     = valid_i & ready_r;
    assign head_s     = fifo_mem_r[rd_ptr_r];
    // A frame may only begin with something buffered and the peer ready.
    assign start_ok_s = (count_r != COUNT_ZERO) & cts_sync_r;

    assign ready_o      = ready_r;
    assign tx_serial_o  = tx_r;
    assign busy_o       = busy_r;
    assign fifo_count_o = count_r;

    // Two-flop synchronizer for the asynchronous clear-to-send input.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cts_meta_r <= 1'b0;
            cts_sync_r <= 1'b0;
        end else begin
            cts_meta_r <= cts_i;
            cts_sync_r <= cts_meta_r;
        end
    end

    // Storage array; no reset needed because the pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Occupancy after this cycle's push and/or pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, count and a registered ready that tracks the new count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != FULL_COUNT);
        end
    end

    // Frame sequencing; the line level for the next cycle is computed here so
    // the output flop changes on the same edge as the state it belongs to.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        tx_next_s    = tx_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = head_s;
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = ST_START;
                    tx_next_s    = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                    tx_next_s    = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    idx_next_s   = 3'd0;
                    state_next_s = ST_DATA;
                    tx_next_s    = shift_r[0];
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                    tx_next_s  = 1'b0;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                        tx_next_s    = 1'b1;
                    end else begin
                        idx_next_s   = idx_r + 3'd1;
                        shift_next_s = {1'b0, shift_r[7:1]};
                        tx_next_s    = shift_r[1];
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == STOP_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (start_ok_s) begin
                        // Back-to-back frame: start bit follows stop with no idle gap.
                        pop_s        = 1'b1;
                        shift_next_s = head_s;
                        state_next_s = ST_START;
                        tx_next_s    = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                        tx_next_s    = 1'b1;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                    tx_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
                tx_next_s    = 1'b1;
            end
        endcase
    end

    // Serializer state and registered line/busy outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            shift_r <= shift_next_s;
            tx_r    <= tx_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_cts.sv
// tb_uart_tx_cts: scoreboard bench for uart_tx_cts at 4 clocks per bit.
// Accepted bytes are queued; a line monitor decodes each frame and compares.
module tb_uart_tx_cts;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       cts;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int frames_done = 0;
    bit in_frame = 1'b0;
    logic [7:0] exp_q[$];
    int start_cyc[$];

    uart_tx_cts #(
        .CLK_HZ(400), .BAUD(100), .FIFO_DEPTH(4), .STOP_BITS(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid), .ready_o(ready),
        .data_i(data), .cts_i(cts), .tx_serial_o(tx), .busy_o(busy),
        .fifo_count_o(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Must be called just after a falling edge; returns just after a falling edge.
    task automatic push_byte(input logic [7:0] b, input int limit);
        int n = 0;
        bit ok = 1'b0;
        valid = 1'b1;
        data  = b;
        while (ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (ready === 1'b1) begin
            @(posedge clk);
            exp_q.push_back(b);
            ok = 1'b1;
        end
        check("push_accept", int'(ok), 1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || count != 3'd0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", int'(n < limit), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx_low(input int limit, output int n);
        n = 0;
        while (tx !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Line monitor: decode 8N1 frames from falling-edge samples.
    initial begin : monitor
        logic [FRAME-1:0] s;
        logic [7:0] got;
        bit ok_busy;
        bit ok_shape;
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                in_frame = 1'b1;
                start_cyc.push_back(cyc);
                s[0]    = tx;
                ok_busy = (busy === 1'b1);
                aborted = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (reset_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = tx;
                    if (busy !== 1'b1) ok_busy = 1'b0;
                end
                if (aborted) begin
                    void'(start_cyc.pop_back());
                end else begin
                    ok_shape = 1'b1;
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < CPB; k++)
                            if (s[b*CPB+k] !== s[b*CPB]) ok_shape = 1'b0;
                    if (s[0] !== 1'b0) ok_shape = 1'b0;
                    if (s[9*CPB] !== 1'b1) ok_shape = 1'b0;
                    for (int b = 0; b < 8; b++) got[b] = s[(b+1)*CPB];
                    check("frame_shape", int'(ok_shape), 1);
                    check("frame_busy", int'(ok_busy), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected actual=%0h required=none", got);
                    end else begin
                        check("frame_data", int'(got), int'(exp_q.pop_front()));
                    end
                    frames_done++;
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int n;
        int busy_cnt;
        int idx0;
        int fd;
        bit all_high;
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = 8'h00;
        cts     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 0x55 frame: latency and busy width
        cts = 1'b1;
        repeat (4) @(negedge clk);
        push_byte(8'h55, 50);
        check("lat_count_after_push", int'(count), 1);
        check("lat_tx_before_pop", int'(tx), 1);
        @(negedge clk);
        check("lat_tx_fall", int'(tx), 0);
        check("lat_count_after_pop", int'(count), 0);
        busy_cnt = int'(busy);
        repeat (60) begin
            @(negedge clk);
            busy_cnt += int'(busy);
        end
        check("busy_cycles", busy_cnt, FRAME);
        wait_drain(200);

        // CTS low: FIFO fills, fifth byte held, then release
        cts = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) push_byte(8'(i), 50);
        fork
            push_byte(8'h05, 200);
            begin
                repeat (3) @(negedge clk);
                check("full_ready", int'(ready), 0);
                check("full_count", int'(count), 4);
                check("full_valid_held", int'(valid), 1);
                check("full_tx_idle", int'(tx), 1);
                cts = 1'b1;
                wait_tx_low(10, n);
                check("cts_latency_le3", int'(n <= 3), 1);
            end
        join
        wait_drain(600);

        // Three contiguous frames
        idx0 = start_cyc.size();
        push_byte(8'hC3, 50);
        push_byte(8'h0F, 50);
        push_byte(8'hF0, 50);
        wait_drain(400);
        if (start_cyc.size() >= idx0 + 3) begin
            check("contig_gap1", start_cyc[idx0+1] - start_cyc[idx0], FRAME);
            check("contig_gap2", start_cyc[idx0+2] - start_cyc[idx0+1], FRAME);
        end else begin
            check("contig_frames", start_cyc.size() - idx0, 3);
        end

        // CTS drops during DATA of frame 1 with 2 bytes queued
        cts = 1'b0;
        repeat (3) @(negedge clk);
        push_byte(8'h96, 50);
        push_byte(8'h3A, 50);
        check("hold_count2", int'(count), 2);
        fd = frames_done;
        cts = 1'b1;
        wait_tx_low(10, n);
        repeat (10) @(negedge clk);
        cts = 1'b0;
        n = 0;
        while (frames_done == fd && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_frame1_done", int'(n < 100), 1);
        all_high = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) all_high = 1'b0;
        end
        check("hold_tx_high", int'(all_high), 1);
        check("hold_count1", int'(count), 1);
        cts = 1'b1;
        wait_drain(200);

        // Same-cycle push and pop at count 2
        push_byte(8'h11, 50);
        push_byte(8'h22, 50);
        push_byte(8'h33, 50);
        repeat (38) @(negedge clk);
        check("pp_count_before", int'(count), 2);
        check("pp_tx_stop", int'(tx), 1);
        push_byte(8'h44, 10);
        check("pp_count_after", int'(count), 2);
        check("pp_tx_next_start", int'(tx), 0);
        wait_drain(600);

        // Reset during bit 3 of 0xA5
        push_byte(8'hA5, 50);
        wait_tx_low(10, n);
        push_byte(8'h3C, 50);
        push_byte(8'h7E, 50);
        repeat (15) @(negedge clk);
        check("mid_tx_bit3", int'(tx), 0);
        check("mid_count", int'(count), 2);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_tx", int'(tx), 1);
        check("arst_count", int'(count), 0);
        check("arst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        all_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) all_high = 1'b0;
        end
        check("post_rst_idle", int'(all_high), 1);
        check("post_rst_count", int'(count), 0);

        // Randomized traffic with CTS toggling
        repeat (4) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 9) == 0) cts = ~cts;
                @(negedge clk);
            end
            if (count == 3'd4) cts = 1'b1;
            push_byte(8'($urandom_range(0, 255)), 300);
        end
        cts = 1'b1;
        wait_drain(2500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
